// File: rtl/datapath_pkg.sv
// Shared widths, issue word layout and sequencer state encoding for the issue path.
package datapath_pkg;

   localparam int unsigned CTRL2_W     = 2;
   localparam int unsigned DATA_W      = 4;
   localparam int unsigned WORD_W      = 11;
   localparam int unsigned FIFO_DEPTH  = 4;
   localparam int unsigned PTR_W       = 2;
   localparam int unsigned OCC_W       = 3;
   localparam int unsigned ISSUE_CNT_W = 8;

   // Field order matches the packed in_word layout, MSB first.
   typedef struct packed {
      logic               ctrl1;
      logic [CTRL2_W-1:0] ctrl2;
      logic [DATA_W-1:0]  data1;
      logic [DATA_W-1:0]  data2;
   } issue_word_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } seq_state_e;

endpackage

// File: rtl/issue_fifo.sv
// Four-entry word FIFO with wrapping pointers; clear empties it and beats push/pop.
module issue_fifo
   import datapath_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        push,
   input  logic        pop,
   input  issue_word_t push_word,
   output issue_word_t head,
   output logic        full,
   output logic        empty
);

   issue_word_t      mem_q [FIFO_DEPTH];
   issue_word_t      mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (occ_q == OCC_W'(FIFO_DEPTH));
   assign empty   = (occ_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         occ_d = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage is data-only; validity comes from the occupancy count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/issue_sequencer.sv
// Queues packed words and issues one per cycle into a registered output stage,
// holding on stall, dropping everything on flush, and counting issues.
module issue_sequencer
   import datapath_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [WORD_W-1:0]      in_word,
   output logic                   in_ready,
   input  logic                   stall,
   input  logic                   flush,
   output logic                   ctrl1,
   output logic [CTRL2_W-1:0]     ctrl2,
   output logic [DATA_W-1:0]      data1,
   output logic [DATA_W-1:0]      data2,
   output logic                   out_valid,
   output logic [ISSUE_CNT_W-1:0] issue_count
);

   seq_state_e             state_q, state_d;
   issue_word_t            out_q, out_d;
   logic                   out_valid_q, out_valid_d;
   logic [ISSUE_CNT_W-1:0] issue_count_q, issue_count_d;

   issue_word_t fifo_head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_pop;
   logic        fifo_push;

   assign in_ready  = !fifo_full && !flush && !reset;
   assign fifo_push = in_valid && in_ready;

   issue_fifo u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .push_word (issue_word_t'(in_word)),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Next state and output stage; HOLD released behaves exactly like RUN.
   always_comb begin
      state_d       = state_q;
      out_d         = out_q;
      out_valid_d   = out_valid_q;
      issue_count_d = issue_count_q;
      fifo_pop      = 1'b0;
      if (flush) begin
         state_d       = ST_IDLE;
         out_d         = '0;
         out_valid_d   = 1'b0;
         issue_count_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty && !stall) begin
                  fifo_pop      = 1'b1;
                  out_d         = fifo_head;
                  out_valid_d   = 1'b1;
                  issue_count_d = issue_count_q + ISSUE_CNT_W'(1);
                  state_d       = ST_RUN;
               end
            end
            ST_RUN, ST_HOLD: begin
               if (stall) begin
                  state_d = ST_HOLD;
               end else if (!fifo_empty) begin
                  fifo_pop      = 1'b1;
                  out_d         = fifo_head;
                  out_valid_d   = 1'b1;
                  issue_count_d = issue_count_q + ISSUE_CNT_W'(1);
                  state_d       = ST_RUN;
               end else begin
                  out_d       = '0;
                  out_valid_d = 1'b0;
                  state_d     = ST_IDLE;
               end
            end
            default: begin
               state_d     = ST_IDLE;
               out_d       = '0;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         out_q         <= '0;
         out_valid_q   <= 1'b0;
         issue_count_q <= '0;
      end else begin
         state_q       <= state_d;
         out_q         <= out_d;
         out_valid_q   <= out_valid_d;
         issue_count_q <= issue_count_d;
      end
   end

   assign ctrl1       = out_q.ctrl1;
   assign ctrl2       = out_q.ctrl2;
   assign data1       = out_q.data1;
   assign data2       = out_q.data2;
   assign out_valid   = out_valid_q;
   assign issue_count = issue_count_q;

endmodule

// File: tb/tb_issue_sequencer.sv
// Directed stimulus with a queue-based reference model; a monitor checks every
// cycle's output stage, issue count and in_ready against the model.
module tb_issue_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [10:0] in_word = '0;
   logic        in_ready;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        ctrl1;
   logic [1:0]  ctrl2;
   logic [3:0]  data1;
   logic [3:0]  data2;
   logic        out_valid;
   logic [7:0]  issue_count;

   int n_checks = 0;
   int n_errors = 0;

   issue_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_word     (in_word),
      .in_ready    (in_ready),
      .stall       (stall),
      .flush       (flush),
      .ctrl1       (ctrl1),
      .ctrl2       (ctrl2),
      .data1       (data1),
      .data2       (data2),
      .out_valid   (out_valid),
      .issue_count (issue_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   logic [10:0] exp_q[$];
   logic [10:0] exp_out   = '0;
   logic        exp_valid = 1'b0;
   logic [7:0]  exp_cnt   = '0;

   bit          pre_reset = 1'b1;
   bit          pre_flush = 1'b0;
   bit          pre_stall = 1'b0;
   bit          pre_push  = 1'b0;
   logic [10:0] pre_word  = '0;

   // Capture the inputs that the next rising edge will act on and check in_ready.
   always @(negedge clk) begin
      logic exp_ready;
      exp_ready = !reset && !flush && (exp_q.size() < 4);
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      pre_reset = reset;
      pre_flush = flush;
      pre_stall = stall;
      pre_push  = in_valid && exp_ready;
      pre_word  = in_word;
   end

   // Advance the model for the edge just taken, then compare the output stage.
   always @(posedge clk) begin
      #2;
      if (pre_reset || pre_flush) begin
         exp_q.delete();
         exp_out   = '0;
         exp_valid = 1'b0;
         exp_cnt   = '0;
      end else begin
         if (!pre_stall) begin
            if (exp_q.size() > 0) begin
               exp_out   = exp_q.pop_front();
               exp_valid = 1'b1;
               exp_cnt   = exp_cnt + 8'd1;
            end else begin
               exp_out   = '0;
               exp_valid = 1'b0;
            end
         end
         if (pre_push) exp_q.push_back(pre_word);
      end
      chk("out_word", 32'({ctrl1, ctrl2, data1, data2}), 32'(exp_out));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("issue_count", 32'(issue_count), 32'(exp_cnt));
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [10:0] burst [5] = '{11'h0F1, 11'h1E2, 11'h2D3, 11'h3C4, 11'h4B5};

   initial begin
      tick(2);
      reset = 1'b0;
      tick(1);

      // Single word: accepted at edge 1, visible after edge 2
      in_valid = 1'b1;
      in_word  = 11'h5A3;
      tick(1);
      in_valid = 1'b0;
      tick(1);
      chk("t1_ctrl1", 32'(ctrl1), 32'd1);
      chk("t1_ctrl2", 32'(ctrl2), 32'd1);
      chk("t1_data1", 32'(data1), 32'hA);
      chk("t1_data2", 32'(data2), 32'h3);
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_count", 32'(issue_count), 32'd1);
      tick(2);

      // Stall in IDLE while five words are offered; only four fit
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_word  = burst[i];
         if (i == 4) chk("t2_full_ready", 32'(in_ready), 32'd0);
         tick(1);
      end
      in_valid = 1'b0;
      chk("t2_bubble", 32'(out_valid), 32'd0);
      stall = 1'b0;
      tick(4);
      chk("t2_last", 32'({ctrl1, ctrl2, data1, data2}), 32'h3C4);
      tick(1);
      chk("t2_drained", 32'(out_valid), 32'd0);
      tick(1);

      // Issue 11'h100, hold it through a three-cycle stall, then resume
      in_valid = 1'b1;
      in_word  = 11'h100;
      tick(1);
      in_word  = 11'h2C7;
      tick(1);
      in_valid = 1'b0;
      stall    = 1'b1;
      tick(3);
      chk("t3_hold", 32'({ctrl1, ctrl2, data1, data2}), 32'h100);
      stall = 1'b0;
      tick(1);
      chk("t3_resume", 32'({ctrl1, ctrl2, data1, data2}), 32'h2C7);
      tick(2);

      // Flush with three words queued and a same-cycle push
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_word  = burst[i];
         tick(1);
      end
      flush   = 1'b1;
      in_word = 11'h7FF;
      tick(1);
      flush    = 1'b0;
      in_valid = 1'b0;
      stall    = 1'b0;
      chk("t4_valid", 32'(out_valid), 32'd0);
      chk("t4_count", 32'(issue_count), 32'd0);
      tick(2);
      chk("t4_empty", 32'(out_valid), 32'd0);

      // 256 back-to-back issues wrap the counter to zero
      in_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         in_word = 11'(i * 7 + 3);
         tick(1);
      end
      in_valid = 1'b0;
      tick(1);
      chk("t5_wrap_count", 32'(issue_count), 32'd0);
      chk("t5_wrap_valid", 32'(out_valid), 32'd1);
      tick(2);

      // Reset with a full FIFO under stall, then a normal push
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_word  = burst[i];
         tick(1);
      end
      reset = 1'b1;
      tick(1);
      chk("t6_rst_word", 32'({ctrl1, ctrl2, data1, data2}), 32'd0);
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_ready", 32'(in_ready), 32'd0);
      reset    = 1'b0;
      stall    = 1'b0;
      in_valid = 1'b1;
      in_word  = 11'h3C5;
      #1;
      chk("t6_ready", 32'(in_ready), 32'd1);
      tick(1);
      in_valid = 1'b0;
      tick(1);
      chk("t6_word", 32'({ctrl1, ctrl2, data1, data2}), 32'h3C5);
      chk("t6_count", 32'(issue_count), 32'd1);
      tick(3);

      chk("model_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
